// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain_driver: initiator for the ap_ctrl_chain block-level handshake.
// Launches a commanded number of invocations of one child kernel and keeps
// up to MAX_OUT invocations in flight. A timestamp FIFO records the cycle
// counter at each accept, which gives a per-invocation latency at completion.
// Optional watchdog: define ACC_CTRL_TIMEOUT_EN to enable err_timeout and the
// forced FINISH after TIMEOUT_CYCLES cycles without handshake progress.
module ap_ctrl_chain_driver #(
    parameter int ITER_W         = 16,
    parameter int CNT_W          = 32,
    parameter int MAX_OUT        = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ITER_W-1:0] cmd_iters,
    input  logic              done_stall,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              ap_continue,
    output logic              busy,
    output logic              done_pulse,
    output logic [ITER_W-1:0] iters_started,
    output logic [ITER_W-1:0] iters_done,
    output logic [CNT_W-1:0]  last_latency,
    output logic [CNT_W-1:0]  total_cycles,
    output logic              err_unexpected_done,
    output logic              err_timeout
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ITER_W-1:0] iters_q, iters_d;
    logic [ITER_W-1:0] started_q, started_d;
    logic [ITER_W-1:0] done_q, done_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              start_q, start_d;
    logic              cont_q, cont_d;
    logic [CNT_W-1:0]  now_q;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              err_ud_q, err_ud_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ts_mem [MAX_OUT];

    logic cmd_fire;
    logic accept;
    logic complete;
    logic cpl_ok;
    logic cpl_bad;
    logic active;
    logic timeout_hit;

    assign cmd_fire = cmd_valid && (state_q == S_IDLE);
    assign accept   = start_q && ap_ready;
    assign complete = ap_done && cont_q;
    // A completion only counts when something is in flight and the command
    // still expects completions; anything else is flagged and ignored.
    assign cpl_ok   = complete && (out_q != '0) && (done_q < iters_q);
    assign cpl_bad  = complete && !cpl_ok;
    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);

    // ap_idle is informational only and never steers the handshake.
    logic unused_ok;
    assign unused_ok = ap_idle ^ (TIMEOUT_CYCLES == 0);

`ifdef ACC_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_to_q, err_to_d;

    // Watchdog: reloads on any handshake progress, counts while running.
    always_comb begin
        wd_d        = wd_q;
        timeout_hit = 1'b0;
        if (cmd_fire || accept || complete) begin
            wd_d = '0;
        end else if (active) begin
            wd_d = wd_q + 1'b1;
            if (wd_d == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_hit = 1'b1;
            end
        end
        err_to_d = err_to_q | timeout_hit;
    end

    // Watchdog registers; the timeout flag is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_iters == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (timeout_hit) begin
                    state_d = S_FINISH;
                end else if (accept && (started_d == iters_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (timeout_hit) begin
                    state_d = S_FINISH;
                end else if (cpl_ok && (done_d == iters_q)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        done_pulse = (state_q == S_FINISH);
    end

    // Counter, latency and handshake next-state values.
    always_comb begin
        iters_d   = iters_q;
        started_d = started_q;
        done_d    = done_q;
        out_d     = out_q;
        lat_d     = lat_q;
        total_d   = total_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_ud_d  = err_ud_q | cpl_bad;

        if (cmd_fire) begin
            // New command: per-command state restarts, sticky errors stay.
            iters_d   = cmd_iters;
            started_d = '0;
            done_d    = '0;
            out_d     = '0;
            lat_d     = '0;
            total_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            if (accept && (started_q < iters_q)) begin
                started_d = started_q + 1'b1;
            end
            if (accept) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (cpl_ok) begin
                done_d   = done_q + 1'b1;
                lat_d    = now_q - ts_mem[rd_ptr_q];
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            // Simultaneous accept and completion leave the count unchanged.
            if (accept && !cpl_ok) begin
                out_d = out_q + 1'b1;
            end else if (!accept && cpl_ok) begin
                out_d = out_q - 1'b1;
            end
            if (state_q != S_IDLE) begin
                total_d = total_q + 1'b1;
            end
        end

        // A raised ap_start is held until accepted; a fresh start needs a
        // remaining iteration and room for another in-flight invocation.
        start_d = (state_d == S_RUN) &&
                  ((start_q && !accept) ||
                   ((started_d < iters_d) && (out_d < OUT_MAX)));
        cont_d  = ((state_d == S_RUN) || (state_d == S_DRAIN)) && !done_stall;
    end

    // Control and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            iters_q   <= '0;
            started_q <= '0;
            done_q    <= '0;
            out_q     <= '0;
            start_q   <= 1'b0;
            cont_q    <= 1'b0;
            now_q     <= '0;
            lat_q     <= '0;
            total_q   <= '0;
            err_ud_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            iters_q   <= iters_d;
            started_q <= started_d;
            done_q    <= done_d;
            out_q     <= out_d;
            start_q   <= start_d;
            cont_q    <= cont_d;
            now_q     <= now_q + 1'b1;
            lat_q     <= lat_d;
            total_q   <= total_d;
            err_ud_q  <= err_ud_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Timestamp FIFO storage: cycle count captured at each accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            ts_mem[wr_ptr_q] <= now_q;
        end
    end

    assign ap_start            = start_q;
    assign ap_continue         = cont_q;
    assign iters_started       = started_q;
    assign iters_done          = done_q;
    assign last_latency        = lat_q;
    assign total_cycles        = total_q;
    assign err_unexpected_done = err_ud_q;

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Testbench for ap_ctrl_chain_driver with a behavioural kernel stub and a
// latency scoreboard built from observed accept/complete timestamps.
module tb_ap_ctrl_chain_driver;

    localparam int ITER_W  = 16;
    localparam int CNT_W   = 32;
    localparam int MAX_OUT = 2;
    localparam int TO      = 100;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ITER_W-1:0] cmd_iters = '0;
    logic              done_stall = 1'b0;
    logic              ap_start;
    logic              ap_ready = 1'b0;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_continue;
    logic              busy;
    logic              done_pulse;
    logic [ITER_W-1:0] iters_started;
    logic [ITER_W-1:0] iters_done;
    logic [CNT_W-1:0]  last_latency;
    logic [CNT_W-1:0]  total_cycles;
    logic              err_unexpected_done;
    logic              err_timeout;

    ap_ctrl_chain_driver #(
        .ITER_W(ITER_W), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_iters(cmd_iters), .done_stall(done_stall), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .ap_continue(ap_continue), .busy(busy), .done_pulse(done_pulse),
        .iters_started(iters_started), .iters_done(iters_done),
        .last_latency(last_latency), .total_cycles(total_cycles),
        .err_unexpected_done(err_unexpected_done), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // Kernel stub state and scoreboard
    int          cyc = 0;
    int          stub_delay = 10;
    logic        force_done = 1'b0;
    logic        done_due = 1'b0;
    logic        idle_s = 1'b1;
    int          due_q[$];
    int          acc_t[$];
    int          exp_q[$];
    logic [31:0] obs_q[$];
    bit          lat_pend = 0;
    int          bench_out = 0;
    int          max_out = 0;
    int          acc_cnt = 0, busy_cnt = 0, pulse_cnt = 0, start_cnt = 0, start_viol = 0;
    int          n_pass = 0, n_total = 0;

    assign ap_done = force_done | done_due;
    assign ap_idle = idle_s;

    // Stub: ap_done held from the due cycle until acknowledged.
    always @(negedge clock) begin
        done_due = (due_q.size() > 0) && (cyc >= due_q[0]);
        idle_s   = (due_q.size() == 0);
    end

    // Monitor: records handshake events and builds expected latencies.
    always @(posedge clock) begin
        bit acc, cmp;
        acc = ap_start && ap_ready;
        cmp = ap_done && ap_continue;
        if (lat_pend) obs_q.push_back(last_latency);
        lat_pend = 0;
        if (reset) begin
            due_q.delete();
            acc_t.delete();
            bench_out = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done_pulse) pulse_cnt++;
            if (ap_start) start_cnt++;
            if (ap_start && bench_out >= MAX_OUT && !cmp) start_viol++;
            if (cmp && acc_t.size() > 0) begin
                exp_q.push_back(cyc - acc_t.pop_front());
                lat_pend = 1;
                bench_out--;
                if (due_q.size() > 0) void'(due_q.pop_front());
            end
            if (acc) begin
                acc_t.push_back(cyc);
                due_q.push_back(cyc + stub_delay);
                bench_out++;
                acc_cnt++;
            end
            if (bench_out > max_out) max_out = bench_out;
        end
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic send_cmd(input int n);
        int k = 0;
        @(negedge clock);
        while (!cmd_ready && k < 100) begin @(negedge clock); k++; end
        cmd_valid = 1'b1;
        cmd_iters = ITER_W'(n);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_finish(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done_pulse) ok = 1;
            else @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_total++;
        if ({cmd_ready, busy, ap_start, ap_continue, done_pulse} !== 5'b10000) begin
            $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, busy, ap_start, ap_continue, done_pulse});
        end else n_pass++;
        n_total++;
        if ({iters_started, iters_done, last_latency, total_cycles} !== '0) begin
            $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", iters_started, iters_done, last_latency, total_cycles);
        end else n_pass++;
        n_total++;
        if ({err_unexpected_done, err_timeout} !== 2'b00) begin
            $display("FAIL reset_errs: got %b want 00", {err_unexpected_done, err_timeout});
        end else n_pass++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        bit ok;
        int b0, p0, a0, rd;
        ap_ready = 1'b1; stub_delay = 10;
        b0 = busy_cnt; p0 = pulse_cnt; a0 = acc_cnt; rd = exp_q.size();
        send_cmd(3);
        wait_finish(300, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL basic_finish: got no done_pulse want done_pulse"); else n_pass++;
        n_total++;
        if (acc_cnt - a0 !== 3) $display("FAIL basic_accepts: got %0d want 3", acc_cnt - a0); else n_pass++;
        n_total++;
        if (iters_done !== 16'd3 || iters_started !== 16'd3)
            $display("FAIL basic_iters: got %0d/%0d want 3/3", iters_started, iters_done);
        else n_pass++;
        n_total++;
        if (pulse_cnt - p0 !== 1) $display("FAIL basic_pulse: got %0d want 1", pulse_cnt - p0); else n_pass++;
        n_total++;
        if (total_cycles !== 32'(busy_cnt - b0)) $display("FAIL basic_total: got %0d want %0d", total_cycles, busy_cnt - b0); else n_pass++;
        n_total++;
        if ({err_unexpected_done, err_timeout} !== 2'b00) $display("FAIL basic_errs: got %b want 00", {err_unexpected_done, err_timeout}); else n_pass++;
        n_total++;
        if (exp_q.size() - rd !== 3 || obs_q.size() !== exp_q.size())
            $display("FAIL basic_sb_count: got %0d/%0d want 3", exp_q.size() - rd, obs_q.size() - rd);
        else n_pass++;
        while (rd < exp_q.size() && rd < obs_q.size()) begin
            n_total++;
            if (obs_q[rd] !== 32'(exp_q[rd])) $display("FAIL basic_latency[%0d]: got %0d want %0d", rd, obs_q[rd], exp_q[rd]);
            else n_pass++;
            rd++;
        end
        n_total++;
        if (last_latency !== 32'd10) $display("FAIL basic_last_latency: got %0d want 10", last_latency); else n_pass++;
    endtask

    task automatic test_max_out();
        bit ok;
        int v0, rd;
        ap_ready = 1'b1; stub_delay = 20;
        v0 = start_viol; rd = exp_q.size();
        send_cmd(4);
        wait_finish(500, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL maxout_finish: got no done_pulse want done_pulse"); else n_pass++;
        n_total++;
        if (start_viol - v0 !== 0) $display("FAIL maxout_start_blocked: got %0d starts at limit want 0", start_viol - v0); else n_pass++;
        n_total++;
        if (max_out !== MAX_OUT) $display("FAIL maxout_peak: got %0d want %0d", max_out, MAX_OUT); else n_pass++;
        n_total++;
        if (iters_done !== 16'd4) $display("FAIL maxout_iters_done: got %0d want 4", iters_done); else n_pass++;
        while (rd < exp_q.size() && rd < obs_q.size()) begin
            n_total++;
            if (obs_q[rd] !== 32'(exp_q[rd])) $display("FAIL maxout_latency[%0d]: got %0d want %0d", rd, obs_q[rd], exp_q[rd]);
            else n_pass++;
            rd++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        int k, bad, rd;
        ap_ready = 1'b1; stub_delay = 3; done_stall = 1'b1;
        rd = exp_q.size();
        send_cmd(1);
        k = 0;
        while (!ap_done && k < 40) begin @(negedge clock); k++; end
        bad = (ap_done !== 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ap_continue !== 1'b0 || ap_done !== 1'b1 || iters_done !== 16'd0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad); else n_pass++;
        done_stall = 1'b0;
        wait_finish(50, ok);
        n_total++;
        if (ok !== 1'b1 || iters_done !== 16'd1) $display("FAIL stall_release: got done=%0d finish=%0d want 1/1", iters_done, ok); else n_pass++;
        while (rd < exp_q.size() && rd < obs_q.size()) begin
            n_total++;
            if (obs_q[rd] !== 32'(exp_q[rd]) || obs_q[rd] < 32'd8)
                $display("FAIL stall_latency: got %0d want %0d", obs_q[rd], exp_q[rd]);
            else n_pass++;
            rd++;
        end
    endtask

    task automatic test_unexpected();
        bit ok;
        int rd;
        ap_ready = 1'b0; stub_delay = 2;
        rd = exp_q.size();
        send_cmd(1);
        force_done = 1'b1;
        @(negedge clock);
        force_done = 1'b0;
        n_total++;
        if (err_unexpected_done !== 1'b1) $display("FAIL unexp_flag: got %b want 1", err_unexpected_done); else n_pass++;
        n_total++;
        if (iters_done !== 16'd0) $display("FAIL unexp_not_counted: got %0d want 0", iters_done); else n_pass++;
        ap_ready = 1'b1;
        wait_finish(50, ok);
        n_total++;
        if (ok !== 1'b1 || iters_done !== 16'd1) $display("FAIL unexp_recover: got done=%0d finish=%0d want 1/1", iters_done, ok); else n_pass++;
        n_total++;
        if (err_unexpected_done !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", err_unexpected_done); else n_pass++;
        while (rd < exp_q.size() && rd < obs_q.size()) begin
            n_total++;
            if (obs_q[rd] !== 32'(exp_q[rd])) $display("FAIL unexp_latency: got %0d want %0d", obs_q[rd], exp_q[rd]);
            else n_pass++;
            rd++;
        end
    endtask

    task automatic test_zero_iters();
        bit ok;
        int b0, p0, s0;
        ap_ready = 1'b1;
        b0 = busy_cnt; p0 = pulse_cnt; s0 = start_cnt;
        send_cmd(0);
        wait_finish(5, ok);
        n_total++;
        if (busy_cnt - b0 !== 1 || pulse_cnt - p0 !== 1)
            $display("FAIL zero_busy_pulse: got busy=%0d pulse=%0d want 1/1", busy_cnt - b0, pulse_cnt - p0);
        else n_pass++;
        n_total++;
        if (start_cnt - s0 !== 0) $display("FAIL zero_no_start: got %0d want 0", start_cnt - s0); else n_pass++;
        n_total++;
        if (total_cycles !== 32'd1) $display("FAIL zero_total: got %0d want 1", total_cycles); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        ap_ready = 1'b1; stub_delay = 30;
        send_cmd(1);
        k = 0;
        while (iters_started !== 16'd1 && k < 10) begin @(negedge clock); k++; end
        repeat (3) @(negedge clock);
        n_total++;
        if (busy !== 1'b1 || iters_started !== 16'd1) $display("FAIL midrst_pre: got busy=%b started=%0d want 1/1", busy, iters_started); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_total++;
        if ({ap_start, ap_continue, cmd_ready, busy} !== 4'b0010)
            $display("FAIL midrst_ctrl: got %b want 0010", {ap_start, ap_continue, cmd_ready, busy});
        else n_pass++;
        n_total++;
        if ({iters_started, iters_done, last_latency, total_cycles, err_unexpected_done} !== '0)
            $display("FAIL midrst_counters: got %0d %0d %0d %0d %b want 0", iters_started, iters_done, last_latency, total_cycles, err_unexpected_done);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

`ifdef ACC_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int b0;
        ap_ready = 1'b0;
        b0 = busy_cnt;
        send_cmd(1);
        wait_finish(TO + 50, ok);
        n_total++;
        if (ok !== 1'b1 || err_timeout !== 1'b1) $display("FAIL timeout_flag: got finish=%0d err=%b want 1/1", ok, err_timeout); else n_pass++;
        n_total++;
        if (busy_cnt - b0 !== TO + 1) $display("FAIL timeout_cycles: got %0d want %0d", busy_cnt - b0, TO + 1); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max_out();
        test_stall();
        test_unexpected();
        test_zero_iters();
        test_reset_mid();
`ifdef ACC_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
